// File: rtl/intra_recon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : intra_recon_pkg
// Brief    : Shared types, constants and helpers for the intra reconstruction
//            engine (prediction modes, FSM states, pixel clipping).
// Revision : 1.0 - initial release
// ============================================================================
package intra_recon_pkg;

    // Intra prediction mode carried with every block
    typedef enum logic [1:0] {
        MODE_V    = 2'd0,
        MODE_H    = 2'd1,
        MODE_DC   = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    // Engine sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_CALC  = 3'd2,
        ST_WB    = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    // Substitute for any neighbour sample that lies outside the frame
    localparam logic [7:0] PIX_DEFAULT = 8'd128;

    // Saturate a signed intermediate to the 8-bit pixel range
    function automatic logic [7:0] clip8(input logic signed [15:0] value);
        logic [7:0] result;
        if (value < 16'sd0) begin
            result = 8'd0;
        end else if (value > 16'sd255) begin
            result = 8'd255;
        end else begin
            result = value[7:0];
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/recon_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : recon_line_buffer
// Brief    : Single-port synchronous RAM holding the bottom pixel row of the
//            previous block row. One-cycle registered read latency.
// Revision : 1.0 - initial release
// ============================================================================
module recon_line_buffer #(
    parameter int DEPTH = 1280,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);

    logic [7:0] r_mem [DEPTH];
    logic [7:0] r_rdata;

    // Write when enabled; the read port always returns the addressed word one cycle later
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        r_rdata <= r_mem[addr];
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/intra_recon_engine.sv
`default_nettype none
// ============================================================================
// Module   : intra_recon_engine
// Brief    : Intra reconstruction of BLK x BLK blocks. Prediction uses a
//            one-row top line buffer plus a left column register; residue is
//            added with clipping and neighbour storage is refreshed afterwards.
// Revision : 1.0 - initial release
// ============================================================================
module intra_recon_engine
    import intra_recon_pkg::*;
#(
    parameter int BLK    = 4,
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720,
    parameter int RES_W  = 9
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [$clog2(WIDTH/BLK)-1:0] blk_x,
    input  logic [$clog2(HEIGHT/BLK)-1:0] blk_y,
    input  logic [1:0]                   mode,
    input  logic [BLK*BLK*RES_W-1:0]     residue,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [BLK*BLK*8-1:0]         out_pix,
    output logic                         mode_err
);

    localparam int LOG2_BLK = $clog2(BLK);
    localparam int XW       = $clog2(WIDTH/BLK);
    localparam int YW       = $clog2(HEIGHT/BLK);
    // blk_x concatenated with the in-block column gives the line buffer address
    localparam int AW       = XW + LOG2_BLK;
    localparam int NPIX     = BLK * BLK;
    localparam int IDXW     = 2 * LOG2_BLK;
    // FETCH needs BLK+1 counts (one address-only cycle), hence one extra bit
    localparam int CW       = LOG2_BLK + 1;
    localparam int SUM_W    = 13;
    localparam int SW       = RES_W + 2;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_e                 r_state;
    state_e                 w_next_state;
    logic [CW-1:0]          r_cnt;
    logic [LOG2_BLK-1:0]    w_cnt_lo;
    logic [LOG2_BLK-1:0]    w_top_idx;
    logic [IDXW-1:0]        w_bot_idx;
    logic                   w_accept;
    logic                   w_ram_we;
    logic [AW-1:0]          w_ram_addr;
    logic [7:0]             w_ram_rdata;

    logic [XW-1:0]          r_blk_x;
    logic                   r_top_av;
    logic                   r_left_av;
    mode_e                  r_mode;
    logic [NPIX*RES_W-1:0]  r_res;
    logic                   r_mode_err;

    logic [7:0]             r_top  [BLK];
    logic [7:0]             r_left [BLK];
    logic [7:0]             r_pix  [NPIX];

    logic [7:0]             w_top_eff  [BLK];
    logic [7:0]             w_left_eff [BLK];
    logic [SUM_W-1:0]       w_sum_t;
    logic [SUM_W-1:0]       w_sum_l;
    logic [7:0]             w_dc;
    logic [7:0]             w_pred  [NPIX];
    logic signed [SW-1:0]   w_recon_s [NPIX];
    logic [7:0]             w_recon [NPIX];

    assign w_accept   = in_valid & in_ready;
    assign w_cnt_lo   = r_cnt[LOG2_BLK-1:0];
    // Data returned in FETCH count k belongs to the address issued at count k-1
    assign w_top_idx  = LOG2_BLK'(r_cnt - CW'(1));
    assign w_bot_idx  = {LOG2_BLK'(BLK - 1), w_cnt_lo};
    assign w_ram_addr = {r_blk_x, w_cnt_lo};

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------

    // State register; reset returns to IDLE from anywhere, aborting a block
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: FETCH spans BLK+1 cycles to absorb the RAM read latency
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)                 w_next_state = ST_FETCH;
            ST_FETCH: if (r_cnt == CW'(BLK))        w_next_state = ST_CALC;
            ST_CALC:                                w_next_state = ST_WB;
            ST_WB:    if (r_cnt == CW'(BLK - 1))    w_next_state = ST_OUT;
            ST_OUT:   if (out_ready)                w_next_state = ST_IDLE;
            default:                                w_next_state = ST_IDLE;
        endcase
    end

    // State-decoded outputs; reset masks acceptance and line buffer writes
    always_comb begin
        in_ready  = (r_state == ST_IDLE) && !reset;
        out_valid = (r_state == ST_OUT);
        w_ram_we  = (r_state == ST_WB) && !reset;
    end

    // Phase counter for the multi-cycle FETCH and WB states
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_cnt <= '0;
        end else if (r_state == ST_FETCH || r_state == ST_WB) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Input capture
    // ------------------------------------------------------------------------

    // Latch block descriptor and residues on acceptance
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_blk_x   <= blk_x;
            r_top_av  <= (blk_y != YW'(0));
            r_left_av <= (blk_x != XW'(0));
            r_mode    <= mode_e'(mode);
            r_res     <= residue;
        end
    end

    // Reserved-mode flag, a single-cycle pulse after the accepting edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode_err <= 1'b0;
        end else begin
            r_mode_err <= w_accept && (mode_e'(mode) == MODE_RSVD);
        end
    end

    assign mode_err = r_mode_err;

    // ------------------------------------------------------------------------
    // Neighbour storage
    // ------------------------------------------------------------------------

    recon_line_buffer #(
        .DEPTH (WIDTH),
        .AW    (AW)
    ) u_line_buffer (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_pix[w_bot_idx]),
        .rdata (w_ram_rdata)
    );

    // Collect top neighbours as the line buffer returns them
    always_ff @(posedge clk) begin
        if (r_state == ST_FETCH && r_cnt != CW'(0)) begin
            r_top[w_top_idx] <= w_ram_rdata;
        end
    end

    // Right column of the finished block becomes the next block's left neighbours
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < BLK; r++) begin
                r_left[r] <= '0;
            end
        end else if (r_state == ST_WB && r_cnt == CW'(0)) begin
            for (int r = 0; r < BLK; r++) begin
                r_left[r] <= r_pix[r*BLK + BLK - 1];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Prediction and reconstruction
    // ------------------------------------------------------------------------

    // Neighbour substitution, DC average and per-sample clipped reconstruction
    always_comb begin
        w_sum_t = '0;
        w_sum_l = '0;
        for (int i = 0; i < BLK; i++) begin
            w_top_eff[i]  = r_top_av  ? r_top[i]  : PIX_DEFAULT;
            w_left_eff[i] = r_left_av ? r_left[i] : PIX_DEFAULT;
            w_sum_t       = w_sum_t + SUM_W'(r_top[i]);
            w_sum_l       = w_sum_l + SUM_W'(r_left[i]);
        end

        case ({r_top_av, r_left_av})
            2'b11:   w_dc = 8'((w_sum_t + w_sum_l + SUM_W'(BLK)) >> (LOG2_BLK + 1));
            2'b10:   w_dc = 8'((w_sum_t + SUM_W'(BLK / 2)) >> LOG2_BLK);
            2'b01:   w_dc = 8'((w_sum_l + SUM_W'(BLK / 2)) >> LOG2_BLK);
            default: w_dc = PIX_DEFAULT;
        endcase

        for (int r = 0; r < BLK; r++) begin
            for (int c = 0; c < BLK; c++) begin
                case (r_mode)
                    MODE_V:  w_pred[r*BLK + c] = w_top_eff[c];
                    MODE_H:  w_pred[r*BLK + c] = w_left_eff[r];
                    default: w_pred[r*BLK + c] = w_dc;
                endcase
            end
        end

        for (int k = 0; k < NPIX; k++) begin
            w_recon_s[k] = $signed({{2{r_res[k*RES_W + RES_W - 1]}}, r_res[k*RES_W +: RES_W]})
                         + $signed({{(SW-8){1'b0}}, w_pred[k]});
            w_recon[k]   = clip8(16'(w_recon_s[k]));
        end
    end

    // Register the reconstructed block; it stays stable through WB and OUT
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NPIX; k++) begin
                r_pix[k] <= '0;
            end
        end else if (r_state == ST_CALC) begin
            for (int k = 0; k < NPIX; k++) begin
                r_pix[k] <= w_recon[k];
            end
        end
    end

    generate
        for (genvar k = 0; k < NPIX; k++) begin : g_pack
            assign out_pix[k*8 +: 8] = r_pix[k];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_intra_recon_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_intra_recon_engine
// Brief    : Directed self-checking bench for intra_recon_engine (BLK=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_intra_recon_engine;

    localparam int BLK    = 4;
    localparam int WIDTH  = 1280;
    localparam int HEIGHT = 720;
    localparam int RES_W  = 9;
    localparam int NPIX   = BLK * BLK;
    localparam int XW     = $clog2(WIDTH/BLK);
    localparam int YW     = $clog2(HEIGHT/BLK);

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [XW-1:0]           blk_x;
    logic [YW-1:0]           blk_y;
    logic [1:0]              mode;
    logic [NPIX*RES_W-1:0]   residue;
    logic                    out_valid;
    logic                    out_ready;
    logic [NPIX*8-1:0]       out_pix;
    logic                    mode_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    intra_recon_engine #(
        .BLK    (BLK),
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .RES_W  (RES_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .blk_x     (blk_x),
        .blk_y     (blk_y),
        .mode      (mode),
        .residue   (residue),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .mode_err  (mode_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Residue block where every row carries the same four column values
    function automatic logic [NPIX*RES_W-1:0] res_cols(input int c0, input int c1, input int c2, input int c3);
        int col [4];
        logic [NPIX*RES_W-1:0] v;
        col = '{c0, c1, c2, c3};
        v   = '0;
        for (int r = 0; r < BLK; r++)
            for (int c = 0; c < BLK; c++)
                v[(r*BLK + c)*RES_W +: RES_W] = RES_W'(col[c]);
        return v;
    endfunction

    // Expected pixel block where every row carries the same four column values
    function automatic logic [NPIX*8-1:0] pix_cols(input int c0, input int c1, input int c2, input int c3);
        int col [4];
        logic [NPIX*8-1:0] v;
        col = '{c0, c1, c2, c3};
        v   = '0;
        for (int r = 0; r < BLK; r++)
            for (int c = 0; c < BLK; c++)
                v[(r*BLK + c)*8 +: 8] = 8'(col[c]);
        return v;
    endfunction

    // Present one block for a single accepting edge and check the mode_err pulse
    task automatic send(input string tag, input int bx, input int by, input int md,
                        input logic [NPIX*RES_W-1:0] res, input logic exp_err);
        blk_x    = XW'(bx);
        blk_y    = YW'(by);
        mode     = 2'(md);
        residue  = res;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_merr"}, mode_err, exp_err);
    endtask

    // Bounded wait for out_valid; checks latency and that mode_err stays low
    task automatic wait_valid(input string tag);
        int n    = 0;
        int errs = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (mode_err) errs++;
        end
        chk({tag, "_lat"}, n, 2*BLK + 2);
        chk({tag, "_merr_extra"}, errs, 0);
    endtask

    task automatic wait_out(input string tag, input logic [NPIX*8-1:0] exp_pix);
        wait_valid(tag);
        chk({tag, "_pix"}, out_pix, exp_pix);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_vdrop"}, out_valid, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        blk_x     = '0;
        blk_y     = '0;
        mode      = '0;
        residue   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_pix", out_pix, '0);
        chk("rst_mode_err", mode_err, 1'b0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // DC with no neighbours, zero residue
        send("dc0", 0, 0, 2, res_cols(0, 0, 0, 0), 1'b0);
        wait_out("dc0", pix_cols(128, 128, 128, 128));

        // +20 block, then horizontal from its right column
        send("b1", 0, 0, 2, res_cols(20, 20, 20, 20), 1'b0);
        wait_out("b1", pix_cols(148, 148, 148, 148));
        send("h1", 1, 0, 1, res_cols(0, 0, 0, 0), 1'b0);
        wait_out("h1", pix_cols(148, 148, 148, 148));

        // Bottom row 10,20,30,40 at (0,0), then vertical prediction at (0,1)
        send("c1", 0, 0, 0, res_cols(-118, -108, -98, -88), 1'b0);
        wait_out("c1", pix_cols(10, 20, 30, 40));
        send("v1", 0, 1, 0, res_cols(0, 0, 0, 0), 1'b0);
        wait_out("v1", pix_cols(10, 20, 30, 40));

        // DC both available at (1,1): top 148 x4, left 40 x4 -> (592+160+4)>>3 = 94
        send("dcb", 1, 1, 2, res_cols(0, 0, 0, 0), 1'b0);
        wait_out("dcb", pix_cols(94, 94, 94, 94));

        // DC top only at (0,1): top 10,20,30,40 -> (100+2)>>2 = 25
        send("dct", 0, 1, 2, res_cols(0, 0, 0, 0), 1'b0);
        wait_out("dct", pix_cols(25, 25, 25, 25));

        // Clipping at both ends
        send("clhi", 0, 0, 2, res_cols(200, 200, 200, 200), 1'b0);
        wait_out("clhi", pix_cols(255, 255, 255, 255));
        send("cllo", 0, 0, 2, res_cols(-255, -255, -255, -255), 1'b0);
        wait_out("cllo", pix_cols(0, 0, 0, 0));

        // Output back-pressure with a second block waiting
        send("stall", 0, 0, 2, res_cols(0, 0, 0, 0), 1'b0);
        wait_valid("stall");
        blk_x    = '0;
        blk_y    = '0;
        mode     = 2'd2;
        residue  = res_cols(5, 5, 5, 5);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("stall_pix", out_pix, pix_cols(128, 128, 128, 128));
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("stall_in_ready_after", in_ready, 1'b1);
        chk("stall_valid_after", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("stall2_merr", mode_err, 1'b0);
        wait_out("stall2", pix_cols(133, 133, 133, 133));

        // Reset during FETCH aborts the block
        send("abort", 0, 0, 0, res_cols(50, 50, 50, 50), 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort_rst_valid", out_valid, 1'b0);
        chk("abort_rst_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("abort_in_ready", in_ready, 1'b1);
        chk("abort_out_pix", out_pix, '0);
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        chk("abort_no_output", n, 0);

        // Reserved mode behaves as DC and flags mode_err once
        send("m3", 0, 0, 3, res_cols(0, 0, 0, 0), 1'b1);
        wait_out("m3", pix_cols(128, 128, 128, 128));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
